subtrator_serial: RTL and testbench

- Sequential bit-serial subtractor: computes D = A − B − Bin, one bit per clock, LSB first, using a single borrow flip-flop.
- Counterpart of the team's ripple-carry adder datapath (the subtract direction), built serial to trade area for latency.
- Sits beside the adder in the ALU path. Operands are captured on a start handshake; a one-cycle done pulse marks a valid result.

---
 rtl/subtrator_serial.sv | 121 ++++++++++++
 tb/tb_subtrator_serial.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/subtrator_serial.sv
// subtrator_serial
//   Bit-serial subtractor, D = A - B - Bin (modulo 2^WIDTH), one bit per clock,
//   LSB first, using a single borrow flip-flop. Operands are captured on a
//   start handshake. A one-cycle done pulse marks a new result.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start, ready=1
//   SHIFT | one result bit per clock, busy=1, start ignored
//   DONE  | one-cycle done pulse, ready=1, start here chains a new op
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   start          request, accepted on a rising edge while ready=1
//   A, B, Bin      minuend, subtrahend, borrow-in (captured on accept)
//   ready, busy    handshake status
//   done           one-cycle pulse, result outputs are new
//   D              registered difference, held until the next completion
//   Bout           borrow-out (A < B + Bin, unsigned)
//   Ovf            signed two's-complement overflow
//   Zero           D == 0
module subtrator_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             Ovf,
  output logic             Zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             a_sign;
  logic             b_sign;

  logic             a0;
  logic             b0;
  logic             diff;
  logic             brw_nxt;
  logic [WIDTH-1:0] res_nxt;

  assign a0      = a_sr[0];
  assign b0      = b_sr[0];
  assign diff    = a0 ^ b0 ^ brw;
  assign brw_nxt = (~a0 & b0) | (~(a0 ^ b0) & brw);
  // Diff bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign res_nxt = {diff, res_sr[WIDTH-1:1]};

  assign ready = (state == IDLE) || (state == DONE);
  assign busy  = (state == SHIFT);
  assign done  = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      a_sign <= 1'b0;
      b_sign <= 1'b0;
      D      <= '0;
      Bout   <= 1'b0;
      Ovf    <= 1'b0;
      Zero   <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr   <= A;
            b_sr   <= B;
            brw    <= Bin;
            a_sign <= A[WIDTH-1];
            b_sign <= B[WIDTH-1];
            cnt    <= '0;
            state  <= SHIFT;
          end else begin
            state  <= IDLE;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_nxt;
          brw    <= brw_nxt;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            D     <= res_nxt;
            Bout  <= brw_nxt;
            Ovf   <= (a_sign != b_sign) && (res_nxt[WIDTH-1] != a_sign);
            Zero  <= ~|res_nxt;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_subtrator_serial.sv
// tb_subtrator_serial
//   Directed and swept checks of subtrator_serial (WIDTH=4) against an
//   arithmetic reference model of A - B - Bin.
module tb_subtrator_serial;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         Bout;
  logic         Ovf;
  logic         Zero;

  int errs;
  int nchk;

  subtrator_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout),
    .Ovf   (Ovf),
    .Zero  (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {Bout, Ovf, Zero, D}
  function automatic logic [6:0] model(input logic [3:0] a, input logic [3:0] b, input logic bin);
    logic [4:0] full;
    logic [3:0] d;
    logic       ovf;
    full = {1'b0, a} - {1'b0, b} - {4'b0, bin};
    d    = full[3:0];
    ovf  = (a[3] != b[3]) && (d[3] != a[3]);
    return {full[4], ovf, (d == 4'd0), d};
  endfunction

  // Launch one operation from IDLE/DONE; returns edges from accept to done
  // and whether busy/ready looked right on every shift cycle.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                       output int lat, output logic hs_ok);
    int n;
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = 4'($urandom); B = 4'($urandom); Bin = 1'($urandom);
    n = 0;
    hs_ok = 1'b1;
    while (!done && n < 20) begin
      if (!(busy && !ready)) hs_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    lat = n;
  endtask

  task automatic check_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic bin);
    int         lat;
    logic       hs;
    logic [6:0] e;
    e = model(a, b, bin);
    do_op(a, b, bin, lat, hs);
    chk({tag, "_lat"},  lat, W);
    chk({tag, "_hs"},   hs, 1'b1);
    chk({tag, "_d"},    D, e[3:0]);
    chk({tag, "_bout"}, Bout, e[6]);
    chk({tag, "_ovf"},  Ovf, e[5]);
    chk({tag, "_zero"}, Zero, e[4]);
  endtask

  initial begin
    int         lat;
    logic       hs;
    logic [6:0] e;
    logic [3:0] va [4];
    logic [3:0] vb [4];
    logic       vc [4];
    logic [3:0] held;
    int         seen;

    errs = 0;
    nchk = 0;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    #22;
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy",  busy,  1'b0);
    chk("rst_done",  done,  1'b0);
    chk("rst_out",   {Bout, Ovf, Zero, D}, {1'b0, 1'b0, 1'b1, 4'h0});
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, hand computed.
    check_op("9m3", 4'd9, 4'd3, 1'b0);      // D=6 Bout=0 Ovf=0 Zero=0
    chk("9m3_d_hand", D, 4'h6);
    // done is a single-cycle pulse when start is not re-asserted
    @(posedge clk); #1;
    chk("pulse_done", done, 1'b0);
    chk("pulse_ready", ready, 1'b1);
    check_op("3m9", 4'd3, 4'd9, 1'b0);      // D=A Bout=1 Ovf=1
    chk("3m9_hand", {Bout, Ovf, D}, {1'b1, 1'b1, 4'hA});
    check_op("8m1", 4'd8, 4'd1, 1'b0);      // D=7 Bout=0 Ovf=1
    chk("8m1_hand", {Bout, Ovf, D}, {1'b0, 1'b1, 4'h7});
    check_op("0m0b", 4'd0, 4'd0, 1'b1);     // D=F Bout=1 Ovf=0 Zero=0
    chk("0m0b_hand", {Bout, Ovf, Zero, D}, {1'b1, 1'b0, 1'b0, 4'hF});
    check_op("5m5", 4'd5, 4'd5, 1'b0);      // D=0 Zero=1 Bout=0
    chk("5m5_hand", {Bout, Zero, D}, {1'b0, 1'b1, 4'h0});

    // Results hold through a later operation's shift phase.
    check_op("7m2", 4'd7, 4'd2, 1'b0);
    held = D;
    A = 4'd1; B = 4'd2; Bin = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    chk("hold_d", D, 4'd5);
    chk("hold_busy", busy, 1'b1);
    seen = 0;
    while (!done && seen < 20) begin @(posedge clk); #1; seen++; end
    chk("hold_next_d", D, 4'hE);           // 1 - 2 - 1 = -2
    chk("hold_changed", (D != held), 1'b1);

    // start held high: one result every W+1 edges, shift-time inputs ignored.
    va[0] = 4'd12; vb[0] = 4'd5;  vc[0] = 1'b0;
    va[1] = 4'd2;  vb[1] = 4'd7;  vc[1] = 1'b1;
    va[2] = 4'd15; vb[2] = 4'd15; vc[2] = 1'b0;
    va[3] = 4'd6;  vb[3] = 4'd0;  vc[3] = 1'b1;
    @(posedge clk); #1;                     // back to IDLE
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      A = va[i]; B = vb[i]; Bin = vc[i];
      @(posedge clk); #1;                   // accepting edge
      for (int j = 0; j < W; j++) begin
        A = 4'($urandom); B = 4'($urandom); Bin = 1'($urandom);
        @(posedge clk); #1;
        if (j < W - 1) chk("b2b_nodone", done, 1'b0);
      end
      e = model(va[i], vb[i], vc[i]);
      chk("b2b_done", done, 1'b1);
      chk("b2b_res", {Bout, Ovf, Zero, D}, {e[6], e[5], e[4], e[3:0]});
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_idle", {ready, busy, done}, 3'b100);

    // Asynchronous reset on the 2nd shift cycle aborts the operation.
    check_op("pre_rst", 4'd9, 4'd2, 1'b0);
    A = 4'd10; B = 4'd3; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out", {ready, busy, done, Bout, Ovf, Zero, D},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0});
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("abort_nodone", seen, 0);
    check_op("post_rst", 4'd10, 4'd3, 1'b0);

    // Full sweep of every operand combination, chained back to back.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          e = model(4'(a), 4'(b), 1'(c));
          do_op(4'(a), 4'(b), 1'(c), lat, hs);
          chk("sweep", {lat[3:0], hs, Bout, Ovf, Zero, D},
              {4'(W), 1'b1, e[6], e[5], e[4], e[3:0]});
        end

    // Random operations.
    for (int r = 0; r < 200; r++) begin
      logic [3:0] ra;
      logic [3:0] rb;
      logic       rc;
      ra = 4'($urandom); rb = 4'($urandom); rc = 1'($urandom);
      e = model(ra, rb, rc);
      do_op(ra, rb, rc, lat, hs);
      chk("rand", {lat[3:0], hs, Bout, Ovf, Zero, D},
          {4'(W), 1'b1, e[6], e[5], e[4], e[3:0]});
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
